// File: rtl/alu_sequencer.sv
// alu_sequencer: FIFO-buffered request queue that sequences operations onto an external ALU.
// Each legal operation runs SETUP (operands settle), then SAMPLE (ALU drives, result captured), then RESP.
`timescale 1ns/1ps
module alu_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [7:0]  req_a_in,
    input  logic [7:0]  req_b_in,
    input  logic [3:0]  req_cmd_in,
    output logic        rsp_valid_out,
    input  logic        rsp_ready_in,
    output logic [15:0] rsp_data_out,
    output logic        rsp_err_out,
    output logic [7:0]  alu_a_out,
    output logic [7:0]  alu_b_out,
    output logic [3:0]  alu_cmd_out,
    output logic        alu_oe_out,
    input  logic [15:0] alu_d_in,
    output logic        busy_out
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, SETUP, SAMPLE, RESP} state_t;
    state_t      r_state;
    logic [19:0] r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_err;
    logic [19:0] w_head;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_legal;
    assign w_head        = r_mem[r_rptr[AW-1:0]];
    assign w_empty       = r_wptr == r_rptr;
    assign w_full        = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push        = req_valid_in && !w_full;
    assign w_pop         = (r_state == IDLE) && !w_empty;
    assign w_legal       = w_head[19:16] <= 4'd4;
    assign req_ready_out = !w_full;
    assign busy_out      = !w_empty || (r_state != IDLE);
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {req_cmd_in, req_b_in, req_a_in};
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= IDLE;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_err         <= 1'b0;
            rsp_valid_out <= 1'b0;
            rsp_data_out  <= '0;
            rsp_err_out   <= 1'b0;
            alu_a_out     <= '0;
            alu_b_out     <= '0;
            alu_cmd_out   <= 4'hF;
            alu_oe_out    <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state <= SETUP;
                        r_err   <= !w_legal;
                        if (w_legal) begin
                            alu_a_out   <= w_head[7:0];
                            alu_b_out   <= w_head[15:8];
                            alu_cmd_out <= w_head[19:16];
                        end
                    end
                end
                SETUP: begin
                    // Illegal commands spend this cycle with the ALU left idle, then report an error.
                    if (r_err) begin
                        r_state       <= RESP;
                        rsp_valid_out <= 1'b1;
                        rsp_data_out  <= '0;
                        rsp_err_out   <= 1'b1;
                    end else begin
                        r_state    <= SAMPLE;
                        alu_oe_out <= 1'b1;
                    end
                end
                SAMPLE: begin
                    r_state       <= RESP;
                    alu_oe_out    <= 1'b0;
                    alu_a_out     <= '0;
                    alu_b_out     <= '0;
                    alu_cmd_out   <= 4'hF;
                    rsp_valid_out <= 1'b1;
                    rsp_data_out  <= alu_d_in;
                    rsp_err_out   <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready_in) begin
                        r_state       <= IDLE;
                        rsp_valid_out <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
